// File: rtl/logic_diag_pkg.sv
// Shared types for the logic-block sweep sequencer: FSM state encoding and
// the vector-count helper used to size the truth-table ports.
package logic_diag_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_WAIT   = ST_WAIT,
        S_SAMPLE = ST_SAMPLE,
        S_DONE   = ST_DONE
    } state_t;

    function automatic int nvec(input int nIn);
        return 1 << nIn;
    endfunction

endpackage

// File: rtl/logic_diag_settle_ctr.sv
// Loadable down-counter that times the settle window between driving a
// vector and sampling the block output; o_zero flags the end of the window.
module logic_diag_settle_ctr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/logic_diag_seq.sv
// BIST-style sweep controller: walks every input vector of a small logic block,
// captures its truth table and compares it against an expected table.
module logic_diag_seq
    import logic_diag_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [nvec(N_IN)-1:0] exp_tt,
    input  logic                  dut_o,
    output logic [N_IN-1:0]       vec,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [nvec(N_IN)-1:0] cap_tt,
    output logic [N_IN:0]         fail_cnt,
    output logic [N_IN-1:0]       first_fail,
    output logic                  fail_valid
);

    localparam int NVEC = nvec(N_IN);
    localparam int CW   = N_IN + 1;

    state_t            r_state;
    state_t            w_next;
    logic [N_IN-1:0]   r_vec;
    logic [NVEC-1:0]   r_exp;
    logic [NVEC-1:0]   r_cap;
    logic [CW-1:0]     r_fail_cnt;
    logic [N_IN-1:0]   r_first_fail;
    logic              r_fail_valid;
    logic              r_pass;
    logic              w_settle_zero;
    logic              w_mismatch;
    logic              w_last;
    logic [CW-1:0]     w_cnt_next;

    assign w_mismatch = (dut_o != r_exp[r_vec]);
    assign w_last     = (r_vec == N_IN'(NVEC - 1));
    assign w_cnt_next = r_fail_cnt + CW'(w_mismatch);

    // With SETTLE=0 there is no wait window, so the counter is left out entirely.
    generate
        if (SETTLE > 0) begin : g_settle
            localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
            logic w_load;
            logic w_en;
            assign w_load = (w_next == S_WAIT) && (r_state != S_WAIT);
            assign w_en   = (r_state == S_WAIT);
            logic_diag_settle_ctr #(.W(SW)) u_settle (
                .clk        (clk),
                .rst        (rst),
                .i_load     (w_load),
                .i_load_val (SW'(SETTLE - 1)),
                .i_en       (w_en),
                .o_zero     (w_settle_zero)
            );
        end else begin : g_no_settle
            assign w_settle_zero = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && !abort) w_next = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
            end
            S_WAIT: begin
                if (abort)              w_next = S_IDLE;
                else if (w_settle_zero) w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)       w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
                else             w_next = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_WAIT) || (r_state == S_SAMPLE);
        done = (r_state == S_DONE);
    end

    // An abort during SAMPLE takes priority over that cycle's capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec        <= '0;
            r_exp        <= '0;
            r_cap        <= '0;
            r_fail_cnt   <= '0;
            r_first_fail <= '0;
            r_fail_valid <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_exp        <= exp_tt;
                        r_cap        <= '0;
                        r_fail_cnt   <= '0;
                        r_fail_valid <= 1'b0;
                        r_pass       <= 1'b0;
                        r_vec        <= '0;
                    end else if (abort) begin
                        r_pass <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        r_vec  <= '0;
                        r_pass <= 1'b0;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        r_vec  <= '0;
                        r_pass <= 1'b0;
                    end else begin
                        r_cap[r_vec] <= dut_o;
                        r_fail_cnt   <= w_cnt_next;
                        if (w_mismatch && !r_fail_valid) begin
                            r_first_fail <= r_vec;
                            r_fail_valid <= 1'b1;
                        end
                        if (w_last) begin
                            r_vec  <= '0;
                            r_pass <= (w_cnt_next == '0);
                        end else begin
                            r_vec <= r_vec + N_IN'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign vec        = r_vec;
    assign pass       = r_pass;
    assign cap_tt     = r_cap;
    assign fail_cnt   = r_fail_cnt;
    assign first_fail = r_first_fail;
    assign fail_valid = r_fail_valid;

endmodule

// File: tb/tb_logic_diag_seq.sv
// Bench for logic_diag_seq: table-driven and random sweeps against a truth-table
// model of the logic block, plus restart, abort and reset-mid-sweep sequences.
module tb_logic_diag_seq;

    localparam int NVEC = 8;

    typedef struct {
        logic [7:0] expTt;
        logic [7:0] fnTt;
        logic [7:0] cap;
        int         cnt;
        int         first;
        logic       valid;
        logic       pass;
    } vec_rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] exp_tt = 8'h00;
    logic [7:0] fn_tt = 8'h00;
    logic       dut_o;
    logic [2:0] vec;
    logic       busy, done, pass, fail_valid;
    logic [7:0] cap_tt;
    logic [3:0] fail_cnt;
    logic [2:0] first_fail;

    logic       start0 = 1'b0;
    logic       abort0 = 1'b0;
    logic       dut_o0;
    logic [2:0] vec0;
    logic       busy0, done0, pass0, fail_valid0;
    logic [7:0] cap_tt0;
    logic [3:0] fail_cnt0;
    logic [2:0] first_fail0;

    int nChecks = 0;
    int nFails  = 0;

    assign dut_o  = fn_tt[vec];
    assign dut_o0 = fn_tt[vec0];

    always #5 clk = ~clk;

    logic_diag_seq #(.N_IN(3), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tt(exp_tt),
        .dut_o(dut_o), .vec(vec), .busy(busy), .done(done), .pass(pass),
        .cap_tt(cap_tt), .fail_cnt(fail_cnt), .first_fail(first_fail),
        .fail_valid(fail_valid)
    );

    logic_diag_seq #(.N_IN(3), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .exp_tt(exp_tt),
        .dut_o(dut_o0), .vec(vec0), .busy(busy0), .done(done0), .pass(pass0),
        .cap_tt(cap_tt0), .fail_cnt(fail_cnt0), .first_fail(first_fail0),
        .fail_valid(fail_valid0)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] expTt, input logic [7:0] fnTt,
                                 input logic st, input logic ab);
        exp_tt = expTt;
        fn_tt  = fnTt;
        start  = st;
        abort  = ab;
    endtask

    // Truth-table model: the captured table is the block's function, mismatches are XOR bits.
    function automatic vec_rec_t computeModel(input logic [7:0] expTt, input logic [7:0] fnTt);
        vec_rec_t r;
        r.expTt = expTt;
        r.fnTt  = fnTt;
        r.cap   = fnTt;
        r.cnt   = 0;
        r.first = 0;
        r.valid = 1'b0;
        for (int v = 0; v < NVEC; v++) begin
            if (fnTt[v] != expTt[v]) begin
                if (!r.valid) r.first = v;
                r.valid = 1'b1;
                r.cnt++;
            end
        end
        r.pass = (r.cnt == 0);
        return r;
    endfunction

    task automatic checkResults(input string tag, input vec_rec_t want);
        checkOutput({tag, ".cap_tt"}, cap_tt, want.cap);
        checkOutput({tag, ".fail_cnt"}, fail_cnt, want.cnt);
        checkOutput({tag, ".fail_valid"}, fail_valid, want.valid);
        checkOutput({tag, ".pass"}, pass, want.pass);
        if (want.valid) checkOutput({tag, ".first_fail"}, first_fail, want.first);
    endtask

    // One full sweep on the SETTLE=1 instance; restartAt>0 re-pulses start mid-sweep.
    task automatic runSweep(input string tag, input vec_rec_t want, input int restartAt);
        int doneCnt = 0;
        int doneAt  = -1;
        @(negedge clk);
        applyStimulus(want.expTt, want.fnTt, 1'b1, 1'b0);
        for (int cyc = 1; cyc <= 22; cyc++) begin
            @(negedge clk);
            start = (cyc == restartAt);
            if (cyc == 1) checkOutput({tag, ".busy_first"}, busy, 1);
            if (cyc <= 2 * NVEC) checkOutput({tag, ".vec_step"}, vec, (cyc - 1) / 2);
            if (doneAt > 0 && cyc == doneAt + 1) checkOutput({tag, ".pass_held"}, pass, want.pass);
            if (done) begin
                doneCnt++;
                if (doneAt < 0) begin
                    doneAt = cyc;
                    checkOutput({tag, ".busy_at_done"}, busy, 0);
                    checkOutput({tag, ".vec_at_done"}, vec, 0);
                    checkResults(tag, want);
                end
            end
        end
        checkOutput({tag, ".done_pulses"}, doneCnt, 1);
        checkOutput({tag, ".done_latency"}, doneAt, 17);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".vec"}, vec, 0);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".done"}, done, 0);
        checkOutput({tag, ".pass"}, pass, 0);
        checkOutput({tag, ".cap_tt"}, cap_tt, 0);
        checkOutput({tag, ".fail_cnt"}, fail_cnt, 0);
        checkOutput({tag, ".first_fail"}, first_fail, 0);
        checkOutput({tag, ".fail_valid"}, fail_valid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_rec_t tbl[4];
        vec_rec_t want;
        int doneCnt;
        int doneAt;

        tbl[0] = '{expTt: 8'hE8, fnTt: 8'hE8, cap: 8'hE8, cnt: 0, first: 0, valid: 1'b0, pass: 1'b1};
        tbl[1] = '{expTt: 8'hE8, fnTt: 8'h00, cap: 8'h00, cnt: 4, first: 3, valid: 1'b1, pass: 1'b0};
        tbl[2] = '{expTt: 8'hE8, fnTt: 8'hFF, cap: 8'hFF, cnt: 4, first: 0, valid: 1'b1, pass: 1'b0};
        tbl[3] = '{expTt: 8'hE8, fnTt: 8'h96, cap: 8'h96, cnt: 6, first: 1, valid: 1'b1, pass: 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("reset");
        checkOutput("reset.busy0", busy0, 0);

        for (int i = 0; i < 4; i++) runSweep($sformatf("table%0d", i), tbl[i], 0);

        runSweep("restart_ignored", tbl[0], 5);

        for (int i = 0; i < 6; i++) begin
            want = computeModel(8'($urandom), 8'($urandom));
            runSweep($sformatf("random%0d", i), want, 0);
        end

        // Abort in the SAMPLE cycle of vector 2: no done pulse, partial results stay.
        @(negedge clk);
        applyStimulus(8'hE8, 8'hFF, 1'b1, 1'b0);
        doneCnt = 0;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (cyc == 6);
            if (done) doneCnt++;
            if (cyc == 7) begin
                checkOutput("abort.busy", busy, 0);
                checkOutput("abort.vec", vec, 0);
                checkOutput("abort.pass", pass, 0);
                checkOutput("abort.fail_valid", fail_valid, 1);
                checkOutput("abort.first_fail", first_fail, 0);
            end
        end
        checkOutput("abort.no_done", doneCnt, 0);

        @(negedge clk);
        applyStimulus(8'hE8, 8'hE8, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(8'hE8, 8'hE8, 1'b0, 1'b0);
        checkOutput("start_abort.busy", busy, 0);
        @(negedge clk);
        checkOutput("start_abort.busy_later", busy, 0);

        // Reset in cycle 9 of a failing sweep, then a clean sweep.
        @(negedge clk);
        applyStimulus(8'hE8, 8'hFF, 1'b1, 1'b0);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetValues("midreset");
        runSweep("after_reset", tbl[0], 0);

        // SETTLE=0 instance: one vector per cycle, back-to-back sweeps.
        for (int s = 0; s < 2; s++) begin
            want = (s == 0) ? tbl[1] : computeModel(8'($urandom), 8'($urandom));
            @(negedge clk);
            exp_tt = want.expTt;
            fn_tt  = want.fnTt;
            start0 = 1'b1;
            doneCnt = 0;
            doneAt  = -1;
            for (int cyc = 1; cyc <= 10; cyc++) begin
                @(negedge clk);
                start0 = 1'b0;
                if (cyc <= NVEC) checkOutput("settle0.vec_step", vec0, cyc - 1);
                if (done0) begin
                    doneCnt++;
                    if (doneAt < 0) begin
                        doneAt = cyc;
                        checkOutput("settle0.cap_tt", cap_tt0, want.cap);
                        checkOutput("settle0.fail_cnt", fail_cnt0, want.cnt);
                        checkOutput("settle0.pass", pass0, want.pass);
                        if (want.valid) checkOutput("settle0.first_fail", first_fail0, want.first);
                    end
                end
                if (cyc == 10) start0 = 1'b1;
            end
            checkOutput("settle0.done_latency", doneAt, 9);
            checkOutput("settle0.done_pulses", doneCnt, 1);
            if (s == 0) begin
                @(negedge clk);
                start0 = 1'b0;
                checkOutput("settle0.back_to_back", busy0, 1);
                for (int cyc = 2; cyc <= 12; cyc++) @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
